sa_tile_engine: RTL

Parametrised N×N output-stationary systolic tile engine: successor of the fixed 8×8 systolic-array top unit. It buffers up to K_MAX operand beats, feeds them to a PE grid with generated row/column skew, and drains the N×N accumulator results row by row over a valid/ready handshake. It adds selectable signed/unsigned arithmetic, a runtime reduction depth and a start/busy/done control handshake. It sits between the tile DMA/scheduler and the post-processing (quantise/activation) stage.

---
 rtl/sa_pkg.sv | 25 ++
 rtl/sa_pe_grid.sv | 115 +++++++++++
 rtl/sa_tile_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the systolic tile engine.
//   sa_state_e  - control FSM states (IDLE, LOAD, FEED, FLUSH, DRAIN)
//   SA_*_DEF    - default array size, operand width and reduction depth
//   acc_width() - accumulator width that cannot overflow for k_max products
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } sa_state_e;

  localparam int SA_N_DEF    = 8;
  localparam int SA_DW_DEF   = 8;
  localparam int SA_KMAX_DEF = 8;

  // A DWxDW product needs 2*DW bits; summing k_max of them needs
  // clog2(k_max) extra bits of headroom.
  function automatic int acc_width(input int dw, input int k_max);
    return 2 * dw + $clog2(k_max);
  endfunction

endpackage

// File: rtl/sa_pe_grid.sv
// sa_pe_grid: N x N output-stationary grid of multiply-accumulate PEs.
//   CLK, RST     - clock, asynchronous active-high reset
//   clr          - restart all accumulators this cycle (current MAC still counts)
//   row_x/row_v  - per-row activation and valid entering column 0
//   col_w/col_v  - per-column weight and valid entering row 0
//   acc          - N x N accumulator array, acc[i][j] = C[i][j]
// Each PE forwards x to the right and w downward through a register and
// accumulates x*w whenever both operands arriving at it are valid.
module sa_pe_grid
  import sa_pkg::*;
#(
  parameter int N      = SA_N_DEF,
  parameter int DW     = SA_DW_DEF,
  parameter int AW     = acc_width(SA_DW_DEF, SA_KMAX_DEF),
  parameter int SIGNED = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic [N*DW-1:0]   row_x,
  input  logic [N-1:0]      row_v,
  input  logic [N*DW-1:0]   col_w,
  input  logic [N-1:0]      col_v,
  output logic [AW-1:0]     acc [N][N]
);

  logic [DW-1:0] x_reg [N][N-1];
  logic          x_vld [N][N-1];
  logic [DW-1:0] w_reg [N-1][N];
  logic          w_vld [N-1][N];

  logic [DW-1:0] x_in  [N][N];
  logic          xv_in [N][N];
  logic [DW-1:0] w_in  [N][N];
  logic          wv_in [N][N];

  // Product of two operands, widened to the accumulator width. Operands are
  // first extended to 2*DW bits so the truncated product is exact for both
  // the signed and the unsigned interpretation.
  function automatic logic [AW-1:0] mac_term(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] ea;
    logic [2*DW-1:0] eb;
    logic [2*DW-1:0] p;
    logic            sx;
    if (SIGNED != 0) begin
      ea = {{DW{a[DW-1]}}, a};
      eb = {{DW{b[DW-1]}}, b};
    end else begin
      ea = {{DW{1'b0}}, a};
      eb = {{DW{1'b0}}, b};
    end
    p  = ea * eb;
    sx = (SIGNED != 0) && p[2*DW-1];
    return {{(AW-2*DW){sx}}, p};
  endfunction

  // Operand routing: column 0 and row 0 take the skewed edge inputs, every
  // other PE takes what its left / upper neighbour registered last cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_in[i][0]  = row_x[i*DW +: DW];
      xv_in[i][0] = row_v[i];
      for (int j = 1; j < N; j++) begin
        x_in[i][j]  = x_reg[i][j-1];
        xv_in[i][j] = x_vld[i][j-1];
      end
    end
    for (int j = 0; j < N; j++) begin
      w_in[0][j]  = col_w[j*DW +: DW];
      wv_in[0][j] = col_v[j];
      for (int i = 1; i < N; i++) begin
        w_in[i][j]  = w_reg[i-1][j];
        wv_in[i][j] = w_vld[i-1][j];
      end
    end
  end

  // MAC and forwarding registers. On clr the old sum is dropped but the
  // product arriving in the same cycle is kept, since the first beat reaches
  // PE(0,0) on the very cycle the accumulators restart.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) begin
          x_reg[i][j] <= '0;
          x_vld[i][j] <= 1'b0;
        end
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N; j++) begin
          w_reg[i][j] <= '0;
          w_vld[i][j] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= (clr ? '0 : acc[i][j]) +
                       ((xv_in[i][j] && wv_in[i][j]) ? mac_term(x_in[i][j], w_in[i][j]) : '0);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) begin
          x_reg[i][j] <= x_in[i][j];
          x_vld[i][j] <= xv_in[i][j];
        end
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N; j++) begin
          w_reg[i][j] <= w_in[i][j];
          w_vld[i][j] <= wv_in[i][j];
        end
    end
  end

endmodule

// File: rtl/sa_tile_engine.sv
// sa_tile_engine: N x N output-stationary systolic tile engine.
//   CLK, RST            - clock, asynchronous active-high reset
//   start, k_len        - begin a tile of k_len operand beats (1..K_MAX)
//   in_valid/in_ready   - operand beat handshake, in_x column / in_w row
//   busy, done, err     - control status; done/err are one-cycle pulses
//   out_valid/out_ready - result row handshake
//   out_row, out_data   - index and contents of the presented result row
// Beats are buffered first, then replayed into the PE grid with row/column
// skew, then the accumulators are drained one row per handshake.
module sa_tile_engine
  import sa_pkg::*;
#(
  parameter  int N      = SA_N_DEF,
  parameter  int DW     = SA_DW_DEF,
  parameter  int K_MAX  = SA_KMAX_DEF,
  parameter  int SIGNED = 1,
  localparam int AW     = acc_width(DW, K_MAX),
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int RW     = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_x,
  input  logic [N*DW-1:0]   in_w,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_row,
  output logic [N*AW-1:0]   out_data
);

  localparam int BW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int TW = $clog2(K_MAX + N);

  sa_state_e      state;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  beat_cnt;
  logic [TW-1:0]  t_cnt;
  logic [RW-1:0]  row_cnt;

  logic [N*DW-1:0] buf_x [K_MAX];
  logic [N*DW-1:0] buf_w [K_MAX];

  logic            k_legal;
  logic            last_beat;
  logic            feed_last;
  logic            flush_last;
  logic            clr;
  logic [N*DW-1:0] row_x;
  logic [N-1:0]    row_v;
  logic [N*DW-1:0] col_w;
  logic [N-1:0]    col_v;
  logic [AW-1:0]   acc [N][N];

  assign k_legal    = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign last_beat  = (beat_cnt == (k_reg - KW'(1)));
  assign feed_last  = (t_cnt == (TW'(k_reg) + TW'(N - 2)));
  assign flush_last = (t_cnt == TW'(N - 1));
  assign clr        = (state == FEED) && (t_cnt == '0);

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_row   = row_cnt;

  // Control FSM. t_cnt is the feed counter in FEED and is reused as the
  // flush counter in FLUSH. done and err are single-cycle registered pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      k_reg    <= '0;
      beat_cnt <= '0;
      t_cnt    <= '0;
      row_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (k_legal) begin
              k_reg    <= k_len;
              beat_cnt <= '0;
              state    <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              t_cnt    <= '0;
              state    <= FEED;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        FEED: begin
          if (feed_last) begin
            t_cnt <= '0;
            state <= FLUSH;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        FLUSH: begin
          if (flush_last) begin
            t_cnt   <= '0;
            row_cnt <= '0;
            state   <= DRAIN;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (row_cnt == RW'(N - 1)) begin
              row_cnt <= '0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand buffer. Contents are only meaningful after a full LOAD, so it
  // carries no reset.
  always_ff @(posedge CLK) begin
    if ((state == LOAD) && in_valid) begin
      buf_x[beat_cnt[BW-1:0]] <= in_x;
      buf_w[beat_cnt[BW-1:0]] <= in_w;
    end
  end

  // Skew generation: row i / column i sees beat t-i, so beat b meets its
  // partner at PE(i,j) exactly at feed step b+i+j. Outside the window the
  // edge inputs are zero and invalid.
  always_comb begin
    logic [TW-1:0] d;
    row_x = '0;
    row_v = '0;
    col_w = '0;
    col_v = '0;
    d     = '0;
    if (state == FEED) begin
      for (int i = 0; i < N; i++) begin
        d = t_cnt - TW'(i);
        if ((t_cnt >= TW'(i)) && (d < TW'(k_reg))) begin
          row_v[i]           = 1'b1;
          row_x[i*DW +: DW]  = buf_x[d[BW-1:0]][i*DW +: DW];
          col_v[i]           = 1'b1;
          col_w[i*DW +: DW]  = buf_w[d[BW-1:0]][i*DW +: DW];
        end
      end
    end
  end

  // Drain mux: the selected accumulator row is only presented in DRAIN so
  // the result bus idles at zero.
  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < N; j++)
        out_data[j*AW +: AW] = acc[row_cnt][j];
    end
  end

  sa_pe_grid #(
    .N      (N),
    .DW     (DW),
    .AW     (AW),
    .SIGNED (SIGNED)
  ) u_grid (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr),
    .row_x (row_x),
    .row_v (row_v),
    .col_w (col_w),
    .col_v (col_v),
    .acc   (acc)
  );

endmodule
